// File: rtl/kgp_logic_pkg.sv
// Shared opcode encodings and helpers for the KGP-RISC bitwise logic unit.
package kgp_logic_pkg;

  localparam int OP_W_DEFAULT = 3;

  localparam logic [OP_W_DEFAULT-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W_DEFAULT-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W_DEFAULT-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W_DEFAULT-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W_DEFAULT-1:0] OP_XNOR = 3'd4;
  localparam logic [OP_W_DEFAULT-1:0] OP_ANDN = 3'd5;
  localparam logic [OP_W_DEFAULT-1:0] OP_XACC = 3'd6;
  localparam logic [OP_W_DEFAULT-1:0] OP_RSVD = 3'd7;

  // Every encoding up to and including XACC is implemented; the rest are reserved.
  function automatic logic is_legal_op(input logic [OP_W_DEFAULT-1:0] op);
    return op <= OP_XACC;
  endfunction

endpackage

// File: rtl/logic_unit_comb.sv
// Purely combinational bitwise core: selects one logic operation of A/B, or
// folds A into the supplied accumulator value for the XACC checksum op.
module logic_unit_comb
  import kgp_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = OP_W_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] result_o,
  output logic             illegal_o
);

  // Operation select; reserved codes produce an all-zero result.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    result_o  = '0;
    illegal_o = !is_legal_op(op_i);
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_ANDN: result_o = a_i & ~b_i;
      OP_XACC: result_o = acc_i ^ a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides,
// a streaming XOR accumulator and zero/parity/illegal result flags.
// S1 holds the raw op result; S2 adds the flags and drives the outputs.
module logic_unit_pipe
  import kgp_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = OP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_last,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_illegal
);

  // Stage 1 state
  logic             s1_v_q;
  logic [WIDTH-1:0] s1_result_q;
  logic             s1_illegal_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_v_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_zero_q;
  logic             s2_parity_q;
  logic             s2_illegal_q;

  // Accumulator
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_eff;

  // Handshake / datapath glue
  logic             s1_ld;
  logic             s2_ld;
  logic             accept;
  logic             xacc_fire;
  logic [WIDTH-1:0] comb_result;
  logic             comb_illegal;

  // A stage may load when it is empty or when the stage after it is draining.
  // in_ready is purely a function of pipeline state, never of in_valid.
  assign s2_ld     = !s2_v_q || out_ready;
  assign s1_ld     = !s1_v_q || s2_ld;
  assign in_ready  = s1_ld;
  assign accept    = in_valid && s1_ld;
  assign xacc_fire = accept && (in_op == OP_XACC);

  // A same-cycle clear makes the accumulator look empty to the incoming word.
  assign acc_eff = acc_clr ? '0 : acc_q;

  logic_unit_comb #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_comb (
    .a_i       (in_a),
    .b_i       (in_b),
    .op_i      (in_op),
    .acc_i     (acc_eff),
    .result_o  (comb_result),
    .illegal_o (comb_illegal)
  );

  // Accumulator next state: only an accepted XACC advances it (closing the
  // stream on in_last); otherwise a clear empties it, else it holds.
  always_comb begin
    acc_d = acc_q;
    if (xacc_fire) begin
      acc_d = in_last ? '0 : comb_result;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  // Accumulator register; advances at accept regardless of downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all clocked state so every register
      // samples the pre-edge values of its neighbours.
      acc_q <= acc_d;
    end
  end

  // Stage 1: capture the op result and illegal bit of an accepted bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so the outputs are defined zeros
      // straight out of reset rather than whatever the flops powered up with.
      s1_v_q       <= 1'b0;
      s1_result_q  <= '0;
      s1_illegal_q <= 1'b0;
    end else if (s1_ld) begin
      s1_v_q <= accept;
      if (accept) begin
        s1_result_q  <= comb_result;
        s1_illegal_q <= comb_illegal;
      end
    end
  end

  // Stage 2: move S1 forward and derive the zero/parity flags from its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q       <= 1'b0;
      s2_result_q  <= '0;
      s2_zero_q    <= 1'b0;
      s2_parity_q  <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else if (s2_ld) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_result_q  <= s1_result_q;
        s2_zero_q    <= (s1_result_q == '0);
        s2_parity_q  <= ^s1_result_q;
        s2_illegal_q <= s1_illegal_q;
      end
    end
  end

  assign out_valid   = s2_v_q;
  assign out_result  = s2_result_q;
  assign out_zero    = s2_zero_q;
  assign out_parity  = s2_parity_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: a 32-bit and an 8-bit instance
// share a clock and reset. Each has a transaction-level reference model (an
// in-order queue of expected results plus a software accumulator) checked
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0 = WIDTH 32 instance, index 1 = WIDTH 8 instance.
  logic [1:0]       in_valid, in_last, acc_clr, out_ready;
  logic [1:0][31:0] in_a, in_b;
  logic [1:0][2:0]  in_op;
  wire  [1:0]       in_ready, out_valid, out_zero, out_parity, out_illegal;
  wire  [1:0][31:0] out_result;
  wire  [7:0]       res8;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit lat_chk = 1'b0;
  int qsize [2];

  logic_unit_pipe #(.WIDTH(32), .OP_W(3)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_op(in_op[0]),
    .in_last(in_last[0]), .acc_clr(acc_clr[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_result(out_result[0]), .out_zero(out_zero[0]),
    .out_parity(out_parity[0]), .out_illegal(out_illegal[0])
  );

  logic_unit_pipe #(.WIDTH(8), .OP_W(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1][7:0]), .in_b(in_b[1][7:0]), .in_op(in_op[1]),
    .in_last(in_last[1]), .acc_clr(acc_clr[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_result(res8), .out_zero(out_zero[1]),
    .out_parity(out_parity[1]), .out_illegal(out_illegal[1])
  );
  assign out_result[1] = {24'd0, res8};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics of one operation, straight from the opcode table.
  function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a, b, acc, mask);
    logic [31:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a | b);
      3'd4:    r = ~(a ^ b);
      3'd5:    r = a & ~b;
      3'd6:    r = acc ^ a;
      default: r = 32'd0;
    endcase
    return r & mask;
  endfunction

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          c;
  } item_t;

  // Per-instance scoreboard: accepted bundles queue up in order and must
  // come out in order; occupancy alone predicts in_ready.
  for (genvar k = 0; k < 2; k++) begin : g_mon
    localparam logic [31:0] MASK = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    item_t       q[$];
    logic [31:0] acc_m = '0;
    bit          stall = 1'b0;
    logic [31:0] st_res;
    logic [2:0]  st_flags;

    always @(negedge clk) begin
      item_t       it;
      logic [31:0] acc_eff;
      if (!rst_n) begin
        q.delete();
        acc_m = '0;
        stall = 1'b0;
        check($sformatf("rst_out_valid%0d", k), {31'd0, out_valid[k]}, 32'd0);
        check($sformatf("rst_out_result%0d", k), out_result[k], 32'd0);
      end else begin
        check($sformatf("in_ready%0d", k), {31'd0, in_ready[k]},
              {31'd0, (q.size() < 2) || out_ready[k]});
        if (stall) begin
          check($sformatf("stall_valid%0d", k), {31'd0, out_valid[k]}, 32'd1);
          check($sformatf("stall_result%0d", k), out_result[k], st_res);
          check($sformatf("stall_flags%0d", k),
                {29'd0, out_zero[k], out_parity[k], out_illegal[k]}, {29'd0, st_flags});
        end
        if (out_valid[k]) begin
          if (q.size() == 0) begin
            check($sformatf("spurious_out%0d", k), {31'd0, out_valid[k]}, 32'd0);
          end else begin
            it = q[0];
            check($sformatf("result%0d", k), out_result[k], it.res);
            check($sformatf("zero%0d", k), {31'd0, out_zero[k]}, {31'd0, it.res == 32'd0});
            check($sformatf("parity%0d", k), {31'd0, out_parity[k]}, {31'd0, ^it.res});
            check($sformatf("illegal%0d", k), {31'd0, out_illegal[k]}, {31'd0, it.ill});
            if (lat_chk) check($sformatf("latency%0d", k), cyc - it.c, 32'd2);
            if (out_ready[k]) void'(q.pop_front());
          end
        end
        stall    = out_valid[k] && !out_ready[k];
        st_res   = out_result[k];
        st_flags = {out_zero[k], out_parity[k], out_illegal[k]};
        if (in_valid[k] && in_ready[k]) begin
          acc_eff = acc_clr[k] ? 32'd0 : acc_m;
          it.res  = model_op(in_op[k], in_a[k] & MASK, in_b[k] & MASK, acc_eff, MASK);
          it.ill  = (in_op[k] == 3'd7);
          it.c    = cyc;
          q.push_back(it);
          if (in_op[k] == 3'd6) acc_m = in_last[k] ? 32'd0 : it.res;
          else if (acc_clr[k])  acc_m = 32'd0;
        end else if (acc_clr[k]) begin
          acc_m = 32'd0;
        end
      end
      qsize[k] = q.size();
    end
  end

  // Present one bundle to the 32-bit instance and hold it until accepted.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, b, input logic last, clr);
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_op[0] = op; in_a[0] = a; in_b[0] = b;
    in_last[0] = last; acc_clr[0] = clr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready[0]) break;
    end
    check("drive_accepted", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; in_last[0] = 1'b0; acc_clr[0] = 1'b0;
  endtask

  // The bundle accepted by the last drive must appear two cycles later.
  task automatic expect_out(input string name, input logic [31:0] res, input logic z, p, ill);
    @(negedge clk);
    @(negedge clk);
    check({name, "_valid"},   {31'd0, out_valid[0]},   32'd1);
    check({name, "_result"},  out_result[0],           res);
    check({name, "_zero"},    {31'd0, out_zero[0]},    {31'd0, z});
    check({name, "_parity"},  {31'd0, out_parity[0]},  {31'd0, p});
    check({name, "_illegal"}, {31'd0, out_illegal[0]}, {31'd0, ill});
  endtask

  task automatic expect_res(input string name, input logic [31:0] res);
    expect_out(name, res, res == 32'd0, ^res, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] op_exp [6];
  logic [31:0] bp_words [4];
  int          acc_cnt, out_cnt;

  initial begin
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; acc_clr = '0; out_ready = 2'b11;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    lat_chk = 1'b1;

    // Reset in the middle of traffic, with the accumulator loaded.
    drive(3'd6, 32'h0000_5A5A, 32'd0, 1'b0, 1'b0);
    drive(3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid",  {31'd0, out_valid[0]}, 32'd0);
    check("async_rst_result", out_result[0], 32'd0);
    check("async_rst_flags",  {29'd0, out_zero[0], out_parity[0], out_illegal[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    drive(3'd6, 32'h0000_0007, 32'd0, 1'b0, 1'b0);
    expect_res("post_rst_acc", 32'h0000_0007);
    drive(3'd6, 32'h0000_0007, 32'd0, 1'b1, 1'b0);
    expect_res("post_rst_close", 32'h0000_0000);

    // Every logic op on the same operands.
    op_exp = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB,
               32'h000F_0000, 32'h00FF_1234, 32'hF000_0000};
    for (int i = 0; i < 6; i++) begin
      drive(3'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0);
      expect_res($sformatf("op%0d", i), op_exp[i]);
    end

    // Checksum stream, restart after last, and a clear in the same cycle.
    drive(3'd6, 32'h0000_00FF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    expect_res("xacc0", 32'h0000_00FF);
    drive(3'd6, 32'h0000_FF00, 32'hDEAD_BEEF, 1'b0, 1'b0);
    expect_res("xacc1", 32'h0000_FFFF);
    drive(3'd6, 32'hFFFF_0000, 32'hDEAD_BEEF, 1'b1, 1'b0);
    expect_res("xacc_last", 32'hFFFF_FFFF);
    drive(3'd6, 32'h0000_0001, 32'd0, 1'b0, 1'b0);
    expect_res("xacc_restart", 32'h0000_0001);
    drive(3'd6, 32'h0000_00A0, 32'd0, 1'b0, 1'b0);
    expect_res("xacc_more", 32'h0000_00A1);
    drive(3'd6, 32'h0000_0005, 32'd0, 1'b0, 1'b1);
    expect_res("xacc_clr", 32'h0000_0005);
    drive(3'd1, 32'h0000_0000, 32'd0, 1'b0, 1'b1);
    expect_res("clr_only", 32'h0000_0000);
    drive(3'd6, 32'h0000_0030, 32'd0, 1'b0, 1'b0);
    expect_res("xacc_after_clr", 32'h0000_0030);

    // Flags.
    drive(3'd2, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    expect_out("flag_xor_zero", 32'h0, 1'b1, 1'b0, 1'b0);
    drive(3'd1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    expect_out("flag_or_parity", 32'h1, 1'b0, 1'b1, 1'b0);
    drive(3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
    expect_out("flag_rsvd", 32'h0, 1'b1, 1'b0, 1'b1);
    drive(3'd6, 32'h0000_0000, 32'd0, 1'b0, 1'b0);
    expect_res("rsvd_kept_acc", 32'h0000_0030);

    // Backpressure: four words against a stalled consumer.
    lat_chk = 1'b0;
    bp_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    acc_cnt = 0;
    out_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      out_ready[0] = (t >= 4);
      in_valid[0]  = (acc_cnt < 4);
      in_op[0]     = 3'd1;
      in_b[0]      = 32'd0;
      in_a[0]      = bp_words[(acc_cnt < 4) ? acc_cnt : 3];
      @(negedge clk);
      if (t == 3) begin
        check("bp_accepts", acc_cnt, 32'd2);
        check("bp_in_ready_low", {31'd0, in_ready[0]}, 32'd0);
        check("bp_held_result", out_result[0], bp_words[0]);
      end
      if (out_valid[0] && out_ready[0]) begin
        if (out_cnt < 4) check($sformatf("bp_order%0d", out_cnt), out_result[0], bp_words[out_cnt]);
        out_cnt++;
      end
      if (in_valid[0] && in_ready[0]) acc_cnt++;
    end
    check("bp_delivered", out_cnt, 32'd4);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;

    // Random traffic on both widths with random backpressure.
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_op[k]     = 3'($urandom_range(0, 7));
        in_a[k]      = $urandom;
        in_b[k]      = ($urandom_range(0, 7) == 0) ? in_a[k] : $urandom;
        in_last[k]   = ($urandom_range(0, 3) == 0);
        acc_clr[k]   = ($urandom_range(0, 7) == 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
    end

    // Drain.
    @(posedge clk); #1;
    in_valid = '0; in_last = '0; acc_clr = '0; out_ready = 2'b11;
    repeat (6) @(negedge clk);
    check("drain32", qsize[0], 32'd0);
    check("drain8",  qsize[1], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
